// File: rtl/mul_pkg.sv
// Shared encodings for the multiplier issue front-end: op codes, sign selects,
// controller states and the op-to-sign-select / result-half helpers.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam logic [1:0] SEL_SS = 2'b00;
    localparam logic [1:0] SEL_SU = 2'b01;
    localparam logic [1:0] SEL_UU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } mul_ctrl_state_t;

    function automatic logic [1:0] op_to_sel(input logic [1:0] op);
        logic [1:0] sel;
        case (op)
            MUL_OP_MULHSU: sel = SEL_SU;
            MUL_OP_MULHU:  sel = SEL_UU;
            default:       sel = SEL_SS;
        endcase
        return sel;
    endfunction

    // MUL returns the low word; every MULH* variant returns the high word.
    function automatic logic [31:0] select_result(input logic [1:0] op, input logic [63:0] product);
        return (op == MUL_OP_MUL) ? product[31:0] : product[63:32];
    endfunction

endpackage

// File: rtl/mul_product_cache.sv
// Single-entry product cache: remembers the operands, sign select and 64-bit
// product of the last completed multiply so a matching follow-up skips the multiplier.
module mul_product_cache
    import mul_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_rs1_i,
    input  logic [31:0] lookup_rs2_i,
    input  logic [1:0]  lookup_sel_i,
    input  logic        lookup_is_mul_i,
    output logic        hit_o,
    output logic [63:0] product_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_rs1_i,
    input  logic [31:0] wr_rs2_i,
    input  logic [1:0]  wr_sel_i,
    input  logic [63:0] wr_product_i
);

    logic        valid_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [1:0]  sel_q;
    logic [63:0] product_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
        end
    end

    // NOTE: only the valid bit is reset; the payload is qualified by valid_q,
    // so resetting it would add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            rs1_q     <= wr_rs1_i;
            rs2_q     <= wr_rs2_i;
            sel_q     <= wr_sel_i;
            product_q <= wr_product_i;
        end
    end

    // The low word of a product does not depend on signedness, so MUL may hit
    // an entry produced under any sign select.
    assign hit_o = CACHE_EN && valid_q
                && (lookup_rs1_i == rs1_q) && (lookup_rs2_i == rs2_q)
                && (lookup_is_mul_i || (lookup_sel_i == sel_q));

    assign product_o = product_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing front-end for the 16-cycle radix-4 sequential multiplier:
// holds operands steady while it runs, captures the product and returns one half.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        mul_enable,
    output logic [1:0]  mul_sign_sel,
    output logic [31:0] mul_opA,
    output logic [31:0] mul_opB,
    input  logic        mul_done,
    input  logic [63:0] mul_product
);

    mul_ctrl_state_t state_q, state_d;
    logic        mul_enable_q, mul_enable_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        accept;
    logic [1:0]  req_sel;
    logic        cache_hit;
    logic [63:0] cache_product;
    logic        cache_we;

    assign req_sel = op_to_sel(req_op);

    mul_product_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk             (clk),
        .reset           (reset),
        .lookup_rs1_i    (req_rs1),
        .lookup_rs2_i    (req_rs2),
        .lookup_sel_i    (req_sel),
        .lookup_is_mul_i (req_op == MUL_OP_MUL),
        .hit_o           (cache_hit),
        .product_o       (cache_product),
        .wr_en_i         (cache_we),
        .wr_rs1_i        (opa_q),
        .wr_rs2_i        (opb_q),
        .wr_sel_i        (sel_q),
        .wr_product_i    (mul_product)
    );

    assign req_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready));
    assign accept    = req_valid && req_ready;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        mul_enable_d = mul_enable_q;
        sel_d        = sel_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        resp_data_d  = resp_data_q;
        cache_we     = 1'b0;

        if (flush) begin
            state_d      = ST_IDLE;
            mul_enable_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    // Dropping enable on the capture edge stops the multiplier auto-restarting.
                    if (mul_done) begin
                        resp_data_d  = select_result(op_q, mul_product);
                        cache_we     = 1'b1;
                        mul_enable_d = 1'b0;
                        state_d      = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Accept is only possible from IDLE or a draining RESP, never mid-RUN,
            // so the operand registers stay frozen while the multiplier runs.
            if (accept) begin
                opa_d = req_rs1;
                opb_d = req_rs2;
                sel_d = req_sel;
                op_d  = req_op;
                if (cache_hit) begin
                    resp_data_d = select_result(req_op, cache_product);
                    state_d     = ST_RESP;
                end else begin
                    mul_enable_d = 1'b1;
                    state_d      = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mul_enable_q <= 1'b0;
            sel_q        <= SEL_SS;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= MUL_OP_MUL;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            mul_enable_q <= mul_enable_d;
            sel_q        <= sel_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid   = (state_q == ST_RESP);
    assign resp_data    = resp_data_q;
    assign mul_enable   = mul_enable_q;
    assign mul_sign_sel = sel_q;
    assign mul_opA      = opa_q;
    assign mul_opB      = opb_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a behavioural 16-cycle multiplier
// model, a response scoreboard, a vector table and hand-written corner sequences.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        mul_enable;
    logic [1:0]  mul_sign_sel;
    logic [31:0] mul_opA;
    logic [31:0] mul_opB;
    logic        mul_done;
    logic [63:0] mul_product;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];

    mul_issue_ctrl #(.CACHE_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .mul_enable   (mul_enable),
        .mul_sign_sel (mul_sign_sel),
        .mul_opA      (mul_opA),
        .mul_opB      (mul_opB),
        .mul_done     (mul_done),
        .mul_product  (mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the RV32M definition of each op.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == MUL_OP_MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (op == MUL_OP_MUL || op == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [63:0] model_product(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = (sel == SEL_UU) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (sel == SEL_SS) ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Multiplier model: samples enable, pulses done 16 edges later, clears when enable drops.
    logic       m_busy;
    logic [3:0] m_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy      <= 1'b0;
            m_cnt       <= 4'd0;
            mul_done    <= 1'b0;
            mul_product <= 64'h0;
        end else if (mul_done) begin
            mul_done    <= 1'b0;
            m_busy      <= 1'b0;
            mul_product <= 64'hA5A5_5A5A_DEAD_BEEF;
        end else if (m_busy) begin
            if (!mul_enable) begin
                m_busy <= 1'b0;
            end else if (m_cnt == 4'd15) begin
                mul_done    <= 1'b1;
                mul_product <= model_product(mul_sign_sel, mul_opA, mul_opB);
            end else begin
                m_cnt <= m_cnt + 4'd1;
            end
        end else if (mul_enable) begin
            m_busy <= 1'b1;
            m_cnt  <= 4'd0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check(name, {32'h0, resp_data}, {32'h0, exp});
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},  {63'h0, req_ready},   64'd1);
        check({tag, "_resp_valid"}, {63'h0, resp_valid},  64'd0);
        check({tag, "_resp_data"},  {32'h0, resp_data},   64'd0);
        check({tag, "_mul_enable"}, {63'h0, mul_enable},  64'd0);
        check({tag, "_sign_sel"},   {62'h0, mul_sign_sel}, 64'd0);
        check({tag, "_opA"},        {32'h0, mul_opA},     64'd0);
        check({tag, "_opB"},        {32'h0, mul_opB},     64'd0);
    endtask

    // Present one request, accept it at edge E0, then measure after which edge
    // resp_valid appears and for how many cycles enable ran before done.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_edge, input string name);
        int w;
        int k;
        int en_cycles;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        #1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(exp);
            en_cycles = 0;
            k = 0;
            while (k < 40) begin
                @(negedge clk);
                if (k == 0) req_valid = 1'b0;
                #1;
                if (mul_enable && !mul_done) en_cycles++;
                if (resp_valid) break;
                k++;
            end
            check({name, "_resp_edge"}, 64'(k), 64'(exp_edge));
            check({name, "_enable_cycles"}, 64'(en_cycles), (exp_edge == 0) ? 64'd0 : 64'd17);
            if (resp_valid) begin
                check_resp({name, "_data"});
            end else begin
                void'(sb.pop_front());
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            #1;
            check({name, "_drained"}, {63'h0, resp_valid}, 64'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          edge_n;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int edge_n);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.edge_n = edge_n;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[14];
        logic [31:0] sa, sb_op;
        int seen;
        int w;

        vecs[0]  = mk(MUL_OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 18);
        vecs[1]  = mk(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18);
        vecs[2]  = mk(MUL_OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0);
        vecs[3]  = mk(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18);
        vecs[4]  = mk(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18);
        vecs[5]  = mk(MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        vecs[6]  = mk(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        vecs[7]  = mk(MUL_OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0, ref_mul(MUL_OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0), 18);
        vecs[8]  = mk(MUL_OP_MULH,   32'h1234_5678, 32'h9ABC_DEF0, ref_mul(MUL_OP_MULH,   32'h1234_5678, 32'h9ABC_DEF0), 0);
        vecs[9]  = mk(MUL_OP_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, ref_mul(MUL_OP_MULHU,  32'h1234_5678, 32'h9ABC_DEF0), 18);
        vecs[10] = mk(MUL_OP_MULHSU, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(MUL_OP_MULHSU, 32'h1234_5678, 32'h9ABC_DEF0), 18);
        vecs[11] = mk(MUL_OP_MULHSU, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(MUL_OP_MULHSU, 32'h1234_5678, 32'h9ABC_DEF0), 0);
        vecs[12] = mk(MUL_OP_MULH,   32'h1234_5678, 32'h9ABC_DEF1, ref_mul(MUL_OP_MULH,   32'h1234_5678, 32'h9ABC_DEF1), 18);
        vecs[13] = mk(MUL_OP_MULH,   32'h1234_5679, 32'h9ABC_DEF1, ref_mul(MUL_OP_MULH,   32'h1234_5679, 32'h9ABC_DEF1), 18);

        reset      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_rs1    = 32'h0;
        req_rs2    = 32'h0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_reset_values("in_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("post_reset");

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].edge_n, $sformatf("vec%0d", i));
        end

        // Flush eight cycles into RUN: no response, enable drops, ready returns.
        @(negedge clk);
        req_valid = 1'b1; req_op = MUL_OP_MULH; req_rs1 = 32'h0000_ABCD; req_rs2 = 32'hFFFF_1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_blocks_ready", {63'h0, req_ready}, 64'd0);
        check("flush_pre_enable", {63'h0, mul_enable}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_enable_low", {63'h0, mul_enable}, 64'd0);
        check("flush_resp_valid", {63'h0, resp_valid}, 64'd0);
        check("flush_req_ready", {63'h0, req_ready}, 64'd1);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("flush_no_response", 64'(seen), 64'd0);
        issue(MUL_OP_MULH, 32'h0000_ABCD, 32'hFFFF_1234,
              ref_mul(MUL_OP_MULH, 32'h0000_ABCD, 32'hFFFF_1234), 18, "reissue_after_flush");

        // Flush coincident with done must win: no response and no cache write.
        @(negedge clk);
        req_valid = 1'b1; req_op = MUL_OP_MUL; req_rs1 = 32'h0BAD_F00D; req_rs2 = 32'h0000_0777;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        w = 0;
        while (!mul_done && w < 30) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("done_seen_before_flush", {63'h0, mul_done}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_done_resp_valid", {63'h0, resp_valid}, 64'd0);
        check("flush_done_enable", {63'h0, mul_enable}, 64'd0);
        issue(MUL_OP_MUL, 32'h0BAD_F00D, 32'h0000_0777,
              ref_mul(MUL_OP_MUL, 32'h0BAD_F00D, 32'h0000_0777), 18, "reissue_after_flush_done");

        // Response stalled five cycles, then handed over while new hits stream in.
        sa = 32'hDEAD_BEEF;
        sb_op = 32'h0000_1000;
        @(negedge clk);
        req_valid = 1'b1; req_op = MUL_OP_MULHU; req_rs1 = sa; req_rs2 = sb_op;
        #1;
        check("stall_ready_idle", {63'h0, req_ready}, 64'd1);
        @(posedge clk);
        sb.push_back(ref_mul(MUL_OP_MULHU, sa, sb_op));
        @(negedge clk);
        req_op = MUL_OP_MUL;
        #1;
        w = 0;
        while (!resp_valid && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("stall_resp_arrived", {63'h0, resp_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), {63'h0, resp_valid}, 64'd1);
            check($sformatf("stall%0d_data", i), {32'h0, resp_data}, {32'h0, sb[0]});
            check($sformatf("stall%0d_req_ready", i), {63'h0, req_ready}, 64'd0);
            @(negedge clk);
            #1;
        end
        resp_ready = 1'b1;
        #1;
        check("stall_release_ready", {63'h0, req_ready}, 64'd1);
        check_resp("stall_data_taken");
        @(posedge clk);
        sb.push_back(ref_mul(MUL_OP_MUL, sa, sb_op));
        @(negedge clk);
        req_op = MUL_OP_MULHU;
        #1;
        check("stream0_valid", {63'h0, resp_valid}, 64'd1);
        check("stream0_enable", {63'h0, mul_enable}, 64'd0);
        check_resp("stream0_data");
        @(posedge clk);
        sb.push_back(ref_mul(MUL_OP_MULHU, sa, sb_op));
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("stream1_valid", {63'h0, resp_valid}, 64'd1);
        check_resp("stream1_data");
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check("stream_drained", {63'h0, resp_valid}, 64'd0);

        // Asynchronous reset mid-RUN clears outputs at once and invalidates the cache.
        issue(MUL_OP_MULH, 32'h7654_3210, 32'h8765_4321,
              ref_mul(MUL_OP_MULH, 32'h7654_3210, 32'h8765_4321), 18, "pre_reset_fill");
        @(negedge clk);
        req_valid = 1'b1; req_op = MUL_OP_MULHU; req_rs1 = 32'h7654_3210; req_rs2 = 32'h8765_4321;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b1;
        issue(MUL_OP_MULH, 32'h7654_3210, 32'h8765_4321,
              ref_mul(MUL_OP_MULH, 32'h7654_3210, 32'h8765_4321), 18, "post_reset_miss");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Sequencing front-end for the 16-cycle radix-4 sequential multiplier in the EX stage. Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU), drives and holds the multiplier's enable/sign-select/operand inputs, captures the 64-bit product on `done`, and returns the selected 32-bit half. A one-entry product cache returns back-to-back MULH/MUL pairs on identical operands in one cycle, without re-running the multiplier.

## Interface
- `CACHE_EN`, default 1: 1 enables the product cache; 0 makes every request a miss.
- `clk`  in  1  clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `flush`  in  1  pipeline kill; aborts any operation and drops any pending response.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- `req_rs1`, `req_rs2`  in  32 each  operands.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_data`  out  32  result.
- `mul_enable`  out  1  to multiplier; registered.
- `mul_sign_sel`  out  2  00 signed×signed, 01 signed×unsigned, 10 unsigned×unsigned.
- `mul_opA`, `mul_opB`  out  32 each  registered operands.
- `mul_done`  in  1  one-cycle completion pulse.
- `mul_product`  in  64  product, valid while `mul_done` is high.

## Operation
- States: IDLE, RUN, RESP.
- `req_ready = !flush & (IDLE | (RESP & resp_ready))`. At most one operation is in flight.
- Sign-select map: MUL and MULH → 00, MULHSU → 01, MULHU → 10.
- Accept path:
  - Latch the operands and sign-select into the `mul_op*` / `mul_sign_sel` registers.
  - Compute the cache hit.
  - Hit → RESP, with `resp_data` taken from the cached product.
  - Miss → RUN, with `mul_enable` ← 1.
- Cache hit requires all of:
  - `CACHE_EN`;
  - cache valid;
  - `rs1` and `rs2` both equal to the cached operands;
  - `req_op == MUL`, or the request's sign-select equals the cached sign-select. MUL low bits are signedness-independent.
- RUN:
  - `mul_opA`, `mul_opB` and `mul_sign_sel` are held constant, because the multiplier's product path is combinational on them.
  - On `mul_done`: capture `mul_product`, write the cache `{rs1, rs2, sel, product}` with valid ← 1, set `mul_enable` ← 0 on the same edge, go to RESP.
  - Dropping `mul_enable` prevents the multiplier from auto-restarting.
- Result select: MUL → `product[31:0]`; all other ops → `product[63:32]`.
- RESP:
  - `resp_valid = 1`; `resp_data` is held stable until `resp_ready`.
  - On `resp_ready`: accept a new request in the same cycle if one is offered, else go to IDLE.
- `flush` (any state): next state IDLE, `mul_enable` ← 0, `resp_valid` ← 0, no cache write. Flush beats a coincident `mul_done` and a coincident request.
- A `mul_done` seen outside RUN is ignored.
- The cache is cleared only by reset.

## Timing
- Reset values: IDLE; `mul_enable` 0; `mul_sign_sel` 00; `mul_opA`/`mul_opB` 0; `resp_valid` 0; `resp_data` 0; cache valid 0.
- `req_ready` is combinational and is 1 out of reset.
- Miss latency, with the request accepted at edge E0:
  - The multiplier samples enable at E1 and asserts `done` after E17.
  - The block captures at E18, so `resp_valid` is high after E18: 18 cycles.
- Hit latency: `resp_valid` is high after E0, i.e. 1 cycle. With `resp_ready` held high, hits stream at one per cycle.
- Minimum miss-to-miss spacing is 19 cycles.
- Reset mid-RUN: all outputs return to reset values immediately. The multiplier clears itself because `mul_enable` = 0.

## Structure
- Package `mul_pkg` holds:
  - op encodings `MUL_OP_MUL/MULH/MULHSU/MULHU`;
  - sign-select constants `SEL_SS/SEL_SU/SEL_UU`;
  - the state enum `mul_ctrl_state_t`;
  - the function `op_to_sel()`.
- Sub-module `mul_product_cache` contains the single entry, the hit compare and the write port.
- The FSM and the result select live in the top level.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD → `resp_data` 0xFFFFFFEB exactly 18 cycles after accept; `mul_enable` high for exactly 17 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000 at 18 cycles. A following MUL with the same operands → 0x00000000 one cycle after accept, and `mul_enable` stays 0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. A following MULHSU with the same operands misses (different sign-select) → 0xFFFFFFFF at 18 cycles.
- `flush` asserted 8 cycles into RUN → no `resp_valid`, `mul_enable` 0 on the next cycle, `req_ready` 1. Reissuing the identical request misses and takes 18 cycles.
- `resp_ready` held low for 5 cycles in RESP → `resp_valid` and `resp_data` stable, `req_ready` 0. When `resp_ready` rises, a new request is accepted in that same cycle.
- `reset` asserted asynchronously mid-RUN → outputs at reset values immediately. After release, a request with the prior operands misses (cache invalid).
